// File: rtl/systolic_sched.sv
// Sequencing controller for the weight-stationary INT8 systolic array: clear, weight load, K-beat compute, drain, done.
// Optional build macro SCHED_PERF_CNT_EN adds saturating busy/stall performance counters.
module systolic_sched #(
    parameter int N_ROWS      = 16,
    parameter int N_COLS      = 16,
    parameter int PIPE        = 1,
    parameter int K_W         = 16,
    parameter int WLOAD_BEATS = N_COLS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [K_W-1:0]    k_len,
    input  logic [N_ROWS-1:0] row_mask,
    input  logic              abort,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic              act_valid,
    output logic              act_ready,
    output logic              zero_fill,
    output logic              arr_en,
    output logic              arr_clr,
    output logic              arr_load_weight,
    output logic [N_ROWS-1:0] arr_row_en,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc,
`endif
    output logic              aborted
);

    localparam int DRAIN_CYC = N_ROWS + N_COLS + PIPE - 1;
    localparam int BEAT_W    = $clog2(WLOAD_BEATS + 1);
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(WLOAD_BEATS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic [K_W-1:0]      k_len_q;
    logic [K_W-1:0]      k_cnt;
    logic [N_ROWS-1:0]   mask_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;

    logic start_ok;
    assign start_ok = (state == S_IDLE) && start && (row_mask != '0);

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k_len_q   <= '0;
            k_cnt     <= '0;
            mask_q    <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            err       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            err     <= 1'b0;
            aborted <= 1'b0;
            // Abort outranks every transition, including the final beat of a phase.
            if (state != S_IDLE && abort) begin
                state     <= S_IDLE;
                aborted   <= 1'b1;
                k_cnt     <= '0;
                beat_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            k_len_q   <= k_len;
                            mask_q    <= row_mask;
                            k_cnt     <= '0;
                            beat_cnt  <= '0;
                            drain_cnt <= '0;
                            state     <= S_CLEAR;
                        end else if (start) begin
                            err <= 1'b1;
                        end
                    end
                    S_CLEAR: state <= S_LOAD;
                    S_LOAD: begin
                        if (w_valid) begin
                            if (beat_cnt == BEAT_LAST) begin
                                beat_cnt <= '0;
                                state    <= (k_len_q == '0) ? S_DONE : S_COMPUTE;
                            end else begin
                                beat_cnt <= beat_cnt + BEAT_W'(1);
                            end
                        end
                    end
                    S_COMPUTE: begin
                        if (act_valid) begin
                            if (k_cnt == k_len_q - K_W'(1)) begin
                                k_cnt <= '0;
                                state <= S_DRAIN;
                            end else begin
                                k_cnt <= k_cnt + K_W'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            drain_cnt <= '0;
                            state     <= S_DONE;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_ready         = 1'b0;
        act_ready       = 1'b0;
        zero_fill       = 1'b0;
        arr_en          = 1'b0;
        arr_clr         = 1'b0;
        arr_load_weight = 1'b0;
        done            = 1'b0;
        case (state)
            S_CLEAR: arr_clr = 1'b1;
            S_LOAD: begin
                w_ready         = 1'b1;
                arr_load_weight = w_valid;
            end
            S_COMPUTE: begin
                act_ready = 1'b1;
                arr_en    = act_valid;
            end
            S_DRAIN: begin
                arr_en    = 1'b1;
                zero_fill = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign arr_row_en = (state == S_IDLE) ? '0 : mask_q;

`ifdef SCHED_PERF_CNT_EN
    logic stall_now;
    assign stall_now = ((state == S_COMPUTE) && !act_valid) || ((state == S_LOAD) && !w_valid);

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1)
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (stall_now && perf_stall_cyc != '1)
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_lw_en_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(arr_load_weight && arr_en));
    a_clr_only_clear: assert property (@(posedge clk) disable iff (!rst_n)
        arr_clr |-> (state == S_CLEAR));
    a_row_en_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_IDLE) |-> (arr_row_en == '0));
`endif

endmodule

// File: tb/tb_systolic_sched.sv
// Randomized self-checking bench for systolic_sched; expected outputs come from a phase-interval model of each job.
module tb_systolic_sched;

    localparam int NR        = 4;
    localparam int NC        = 4;
    localparam int PP        = 1;
    localparam int KW        = 16;
    localparam int WB        = 4;
    localparam int DRAIN_LEN = NR + NC + PP - 1;
    localparam int MAXC      = 1024;

    localparam int P_IDLE    = 0;
    localparam int P_CLEAR   = 1;
    localparam int P_LOAD    = 2;
    localparam int P_COMPUTE = 3;
    localparam int P_DRAIN   = 4;
    localparam int P_DONE    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic [NR-1:0] row_mask;
    logic          abort;
    logic          w_valid;
    logic          w_ready;
    logic          act_valid;
    logic          act_ready;
    logic          zero_fill;
    logic          arr_en;
    logic          arr_clr;
    logic          arr_load_weight;
    logic [NR-1:0] arr_row_en;
    logic          busy;
    logic          done;
    logic          err;
    logic          aborted;

    systolic_sched #(
        .N_ROWS(NR), .N_COLS(NC), .PIPE(PP), .K_W(KW), .WLOAD_BEATS(WB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .row_mask(row_mask),
        .abort(abort), .w_valid(w_valid), .w_ready(w_ready), .act_valid(act_valid),
        .act_ready(act_ready), .zero_fill(zero_fill), .arr_en(arr_en), .arr_clr(arr_clr),
        .arr_load_weight(arr_load_weight), .arr_row_en(arr_row_en), .busy(busy),
        .done(done), .err(err), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int job_id = 0;
    bit wv[MAXC];
    bit av[MAXC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packed view: {busy,done,err,aborted,clr,load_weight,en,zero_fill,w_ready,act_ready,row_en}
    function automatic logic [31:0] observed();
        return 32'({busy, done, err, aborted, arr_clr, arr_load_weight, arr_en,
                    zero_fill, w_ready, act_ready, arr_row_en});
    endfunction

    function automatic int phase_of(input int c, input int cut, input logic [NR-1:0] mask,
                                    input int k, input int lend, input int cend, input int dcyc);
        if (mask == '0 || c == 0) return P_IDLE;
        if (cut >= 0 && c > cut) return P_IDLE;
        if (c == 1) return P_CLEAR;
        if (c <= lend) return P_LOAD;
        if (c == dcyc) return P_DONE;
        if (k != 0 && c <= cend) return P_COMPUTE;
        if (k != 0 && c < dcyc) return P_DRAIN;
        return P_IDLE;
    endfunction

    // cut: -1 none, -2 pick a random cycle inside the job, else a fixed cycle; cut_rst selects reset instead of abort.
    task automatic run_job(input int k, input logic [NR-1:0] mask, input int cut_in,
                           input bit cut_rst, input bit spurious);
        int lend, cend, dcyc, n, last, cut, ph;
        logic [31:0] e;
        lend = -1;
        n = 0;
        for (int t = 2; t < MAXC; t++) begin
            if (wv[t]) begin
                n++;
                if (n == WB) begin lend = t; break; end
            end
        end
        cend = lend;
        if (k != 0) begin
            n = 0;
            for (int t = lend + 1; t < MAXC; t++) begin
                if (av[t]) begin
                    n++;
                    if (n == k) begin cend = t; break; end
                end
            end
            dcyc = cend + 1 + DRAIN_LEN;
        end else begin
            dcyc = lend + 1;
        end
        cut = cut_in;
        if (cut == -2) cut = int'($urandom_range(1, dcyc));
        if (mask == '0) cut = -1;
        last = (mask == '0) ? 1 : ((cut >= 0) ? cut + 1 : dcyc);

        for (int c = 0; c <= last + 2; c++) begin
            @(posedge clk);
            #1;
            ph = phase_of(c, cut, mask, k, lend, cend, dcyc);
            start     = (c == 0) || (spurious && ph != P_IDLE && $urandom_range(0, 3) == 0);
            k_len     = (c == 0) ? KW'(k) : KW'($urandom);
            row_mask  = (c == 0) ? mask : NR'($urandom);
            w_valid   = wv[c];
            act_valid = av[c];
            abort     = (c == cut && !cut_rst) || (ph == P_IDLE && $urandom_range(0, 3) == 0);
            rst_n     = !(cut_rst && c == cut);
            @(negedge clk);
            e = '0;
            if (ph != P_IDLE) begin
                e[13] = 1'b1;
                e[NR-1:0] = mask;
            end
            e[12] = (ph == P_DONE);
            e[11] = (mask == '0 && c == 1);
            e[10] = (cut >= 0 && !cut_rst && c == cut + 1);
            e[9]  = (ph == P_CLEAR);
            e[8]  = (ph == P_LOAD) && wv[c];
            e[7]  = ((ph == P_COMPUTE) && av[c]) || (ph == P_DRAIN);
            e[6]  = (ph == P_DRAIN);
            e[5]  = (ph == P_LOAD);
            e[4]  = (ph == P_COMPUTE);
            check($sformatf("job%0d c%0d", job_id, c), observed(), e);
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        job_id++;
    endtask

    task automatic fill_valids(input int pct);
        for (int t = 0; t < MAXC; t++) begin
            wv[t] = (t >= 300) || ($urandom_range(0, 99) < pct);
            av[t] = (t >= 300) || ($urandom_range(0, 99) < pct);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        row_mask  = '0;
        abort     = 1'b0;
        w_valid   = 1'b0;
        act_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("reset", observed(), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        fill_valids(100);
        run_job(3, 4'hF, -1, 1'b0, 1'b0);

        av[6] = 1'b1; av[7] = 1'b0; av[8] = 1'b1; av[9] = 1'b0; av[10] = 1'b1;
        run_job(3, 4'hF, -1, 1'b0, 1'b0);

        fill_valids(100);
        run_job(0, 4'hF, -1, 1'b0, 1'b0);
        run_job(3, 4'h0, -1, 1'b0, 1'b0);
        run_job(2, 4'b0101, -1, 1'b0, 1'b0);
        run_job(3, 4'hF, 7, 1'b0, 1'b0);
        run_job(3, 4'hF, -1, 1'b0, 1'b0);
        run_job(4, 4'hA, 10, 1'b1, 1'b0);
        run_job(1, 4'h3, -1, 1'b0, 1'b1);

        for (int j = 0; j < 40; j++) begin
            int sel;
            fill_valids(75);
            sel = int'($urandom_range(0, 9));
            run_job(int'($urandom_range(0, 12)), NR'($urandom), (sel < 4) ? -2 : -1,
                    sel == 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
